// File: rtl/instr_decode_ctrl.sv
// Multi-cycle fetch/decode/control sequencer for the 8-bit basic processor.
// Fetch -> load IR -> decode (extend_8 captures imm) -> exec -> optional mem/writeback.
module instr_decode_ctrl #(
  parameter int unsigned PC_W = 8,
  parameter int unsigned IW   = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [IW-1:0]   imem_rdata,
  output logic [3:0]      imm_out,
  input  logic [7:0]      ext_imm,
  input  logic            zero_flag,
  output logic            alu_en,
  output logic [3:0]      alu_op,
  output logic            alu_src_imm,
  output logic [1:0]      rd_sel,
  output logic [1:0]      rs_sel,
  output logic            reg_we,
  output logic            mem_re,
  output logic            mem_we,
  input  logic            mem_ready,
  output logic            halted
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  localparam logic [3:0] OpAddi = 4'h5;
  localparam logic [3:0] OpLdi  = 4'h6;
  localparam logic [3:0] OpLd   = 4'hA;
  localparam logic [3:0] OpSt   = 4'hB;
  localparam logic [3:0] OpBz   = 4'hC;
  localparam logic [3:0] OpJmp  = 4'hD;
  localparam logic [3:0] OpHalt = 4'hF;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IW-1:0]   ir_q, ir_d;

  logic [3:0]      op;
  logic            op_is_alu;
  logic            op_is_mem;
  logic [PC_W-1:0] ext_pc;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_rel;

  assign op        = ir_q[IW-1 -: 4];
  assign op_is_alu = ~op[3];
  assign op_is_mem = (op == OpLd) || (op == OpSt);

  // Branch offset is signed: sign-extend for wide PCs, truncate for narrow ones.
  assign ext_pc = PC_W'($signed(ext_imm));
  assign pc_inc = pc_q + PC_W'(1);
  assign pc_rel = pc_q + ext_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        ir_d    = imem_rdata;
        state_d = StDecode;
      end
      StDecode: state_d = StExec;
      StExec: begin
        if (op_is_alu) begin
          state_d = StWb;
        end else if (op_is_mem) begin
          state_d = StMem;
        end else if (op == OpBz) begin
          pc_d    = zero_flag ? pc_rel : pc_inc;
          state_d = StFetch;
        end else if (op == OpJmp) begin
          pc_d    = pc_rel;
          state_d = StFetch;
        end else if (op == OpHalt) begin
          state_d = StHalt;
        end else begin
          pc_d    = pc_inc;
          state_d = StFetch;
        end
      end
      StMem: begin
        if (mem_ready) begin
          if (op == OpLd) begin
            state_d = StWb;
          end else begin
            pc_d    = pc_inc;
            state_d = StFetch;
          end
        end
      end
      StWb: begin
        pc_d    = pc_inc;
        state_d = StFetch;
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // Field outputs follow IR directly; everything else is decoded from the state.
  assign imem_addr = pc_q;
  assign imm_out   = ir_q[3:0];
  assign alu_op    = op;
  assign rd_sel    = ir_q[7:6];
  assign rs_sel    = ir_q[5:4];

  always_comb begin
    imem_en     = 1'b0;
    alu_en      = 1'b0;
    alu_src_imm = 1'b0;
    reg_we      = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      StFetch: imem_en = 1'b1;
      StExec: begin
        alu_en      = op_is_alu;
        alu_src_imm = (op == OpAddi) || (op == OpLdi);
      end
      StMem: begin
        mem_re = (op == OpLd);
        mem_we = (op == OpSt);
      end
      StWb:   reg_we = 1'b1;
      StHalt: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Bench for instr_decode_ctrl: models imem and extend_8, queues expected fetch/alu/writeback/mem
// events from the stimulus and lets a negedge monitor pop and compare them.
`timescale 1ns/1ps
module tb_instr_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [11:0] imem_rdata;
  logic [3:0]  imm_out;
  logic [7:0]  ext_imm;
  logic        zero_flag;
  logic        alu_en;
  logic [3:0]  alu_op;
  logic        alu_src_imm;
  logic [1:0]  rd_sel;
  logic [1:0]  rs_sel;
  logic        reg_we;
  logic        mem_re;
  logic        mem_we;
  logic        mem_ready;
  logic        halted;

  int checks   = 0;
  int failures = 0;
  int mem_wait = 0;

  logic [11:0] imem [256];
  logic [7:0]  fetch_q [$];
  logic [4:0]  alu_q   [$];
  logic [1:0]  we_q    [$];
  logic [8:0]  mem_q   [$];

  always #5 clk = ~clk;

  instr_decode_ctrl #(.PC_W(8), .IW(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imm_out    (imm_out),
    .ext_imm    (ext_imm),
    .zero_flag  (zero_flag),
    .alu_en     (alu_en),
    .alu_op     (alu_op),
    .alu_src_imm(alu_src_imm),
    .rd_sel     (rd_sel),
    .rs_sel     (rs_sel),
    .reg_we     (reg_we),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_ready  (mem_ready),
    .halted     (halted)
  );

  // Synchronous instruction memory and registered extend_8 neighbour.
  always_ff @(posedge clk) begin
    if (imem_en) imem_rdata <= imem[imem_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ext_imm <= 8'h00;
    else      ext_imm <= {{4{imm_out[3]}}, imm_out};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  function automatic logic [31:0] all_outs();
    return {5'b0, imem_en, imem_addr, imm_out, alu_en, alu_op, alu_src_imm, rd_sel, rs_sel,
            reg_we, mem_re, mem_we, halted};
  endfunction

  // Memory responder: hold mem_ready low for mem_wait request cycles, then complete.
  initial begin
    int cnt = 0;
    mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_re || mem_we) begin
        mem_ready = (cnt == mem_wait);
        cnt++;
      end else begin
        mem_ready = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor: pops an expectation for every observable DUT event.
  initial begin
    int       run_len = 0;
    logic     run_w   = 1'b0;
    forever begin
      @(negedge clk);
      if (imem_en) begin
        if (fetch_q.size() == 0) fail("fetch_unexpected");
        else chk("fetch_addr", {24'b0, imem_addr}, {24'b0, fetch_q.pop_front()});
      end
      if (alu_en) begin
        if (alu_q.size() == 0) fail("alu_unexpected");
        else chk("alu_op_src", {27'b0, alu_op, alu_src_imm}, {27'b0, alu_q.pop_front()});
      end
      if (reg_we) begin
        if (we_q.size() == 0) fail("reg_we_unexpected");
        else chk("reg_we_rd", {30'b0, rd_sel}, {30'b0, we_q.pop_front()});
      end
      if (mem_re || mem_we) begin
        run_len++;
        run_w = mem_we;
      end else if (run_len > 0) begin
        if (mem_q.size() == 0) fail("mem_unexpected");
        else chk("mem_req_len", {23'b0, run_w, 8'(run_len)}, {23'b0, mem_q.pop_front()});
        run_len = 0;
      end
    end
  end

  task automatic wait_fetch(input logic [7:0] a);
    bit hit = 1'b0;
    for (int n = 0; n < 300 && !hit; n++) begin
      @(negedge clk);
      if (imem_en && imem_addr == a) hit = 1'b1;
    end
    if (!hit) fail("timeout_fetch");
  endtask

  task automatic wait_halt();
    bit hit = 1'b0;
    for (int n = 0; n < 300 && !hit; n++) begin
      @(negedge clk);
      if (halted) hit = 1'b1;
    end
    if (!hit) fail("timeout_halt");
  endtask

  task automatic wait_alu();
    bit hit = 1'b0;
    for (int n = 0; n < 300 && !hit; n++) begin
      @(negedge clk);
      if (alu_en) hit = 1'b1;
    end
    if (!hit) fail("timeout_alu");
  endtask

  task automatic pulse_run();
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  initial begin
    int en_cnt;
    int halt_cnt;
    rst = 1'b0;
    run = 1'b0;
    zero_flag = 1'b0;
    mem_wait = 3;
    for (int i = 0; i < 256; i++) imem[i] = 12'h900;
    imem[0]     = 12'h51D;  // ADDI rd0, #-3
    imem[1]     = 12'hA40;  // LD rd1
    imem[2]     = 12'hB00;  // ST
    imem[3]     = 12'h7C0;  // MOV rd3
    imem[4]     = 12'h900;  // NOP
    imem[5]     = 12'hC0E;  // BZ #-2
    imem[6]     = 12'hD09;  // JMP #-7 -> 0xFF
    imem[8'hFF] = 12'hD01;  // JMP #+1 -> wraps to 0x00

    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 32'h0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_no_fetch", {31'b0, imem_en}, 32'h0);

    fetch_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h03, 8'h04, 8'h05, 8'h06,
                8'hFF, 8'h00};
    alu_q   = '{{4'h5, 1'b1}, {4'h7, 1'b0}, {4'h7, 1'b0}};
    we_q    = '{2'd0, 2'd1, 2'd3, 2'd3};
    mem_q   = '{{1'b0, 8'd4}, {1'b1, 8'd1}};
    pulse_run();

    wait_fetch(8'h02);
    mem_wait = 0;
    wait_fetch(8'h05);
    zero_flag = 1'b1;
    wait_fetch(8'h05);
    zero_flag = 1'b0;
    wait_fetch(8'hFF);
    imem[0] = 12'hF00;  // HALT on the wrapped fetch
    wait_halt();
    chk("halted_pc", {24'b0, imem_addr}, 32'h0);

    @(negedge clk);
    run = 1'b1;  // must be ignored outside IDLE
    en_cnt = 0;
    halt_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      run = 1'b0;
      en_cnt += int'(imem_en);
      halt_cnt += int'(halted);
    end
    chk("halt_imem_en_cycles", en_cnt, 0);
    chk("halted_sticky_cycles", halt_cnt, 20);
    chk("queues_drained_1", fetch_q.size() + alu_q.size() + we_q.size() + mem_q.size(), 0);

    rst = 1'b0;
    #1 chk("reset_from_halt", all_outs(), 32'h0);
    imem[0] = 12'h0C5;  // ADD rd3
    imem[1] = 12'hF00;
    @(negedge clk);
    rst = 1'b1;
    fetch_q.push_back(8'h00);
    alu_q.push_back({4'h0, 1'b0});
    pulse_run();
    wait_alu();
    #1 rst = 1'b0;
    #1 chk("reset_in_exec", all_outs(), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    en_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      en_cnt += int'(imem_en) + int'(reg_we) + int'(mem_we);
    end
    chk("post_reset_quiet", en_cnt, 0);

    fetch_q.push_back(8'h00);
    alu_q.push_back({4'h0, 1'b0});
    we_q.push_back(2'd3);
    fetch_q.push_back(8'h01);
    pulse_run();
    wait_halt();
    chk("halted_pc_restart", {24'b0, imem_addr}, 32'h1);
    repeat (3) @(negedge clk);
    chk("queues_drained_2", fetch_q.size() + alu_q.size() + we_q.size() + mem_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
